// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: 1149.1 state encoding, instruction codes, DR selection and helper functions.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USER
  } dr_sel_e;

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_BYPASS = '1;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_next = TEST_LOGIC_RESET;
    case (s)
      TEST_LOGIC_RESET: tap_next = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    tap_next = tms ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_DR:        tap_next = tms ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR:       tap_next = tms ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:         tap_next = tms ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:         tap_next = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:         tap_next = tms ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:         tap_next = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:        tap_next = tms ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_IR:        tap_next = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       tap_next = tms ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:         tap_next = tms ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:         tap_next = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:         tap_next = tms ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:         tap_next = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:        tap_next = tms ? SELECT_DR : RUN_TEST_IDLE;
      default:          tap_next = TEST_LOGIC_RESET;
    endcase
  endfunction

  // Shift din into bit len-1 of the active window, LSB leaves; bits above the window are untouched.
  function automatic logic [31:0] shift_lsb_first(input logic [31:0] sr, input logic din,
                                                  input logic [5:0] len);
    logic [31:0] mask;
    mask = (32'd1 << len) - 32'd1;
    return (sr & ~mask) | ((sr >> 1) & (mask >> 1)) | (32'(din) << (len - 6'd1));
  endfunction

endpackage

// File: rtl/jtag_sync.sv
// Per-bit multi-flop synchroniser with a parameterised reset value.
module jtag_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // NOTE: reset is sampled on the clock edge (synchronous); state uses non-blocking assignments.
  always_ff @(posedge clock) begin
    if (!reset) ff <= {STAGES{RESET_VAL}};
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/jtag_sampled_tap.sv
// Oversampled IEEE 1149.1 TAP with IDCODE/BYPASS and an optional external USER data register.
// Define JTAG_TAP_USER_DR_EN to route USER_IR to the user_* ports; otherwise USER_IR acts as BYPASS.
module jtag_sampled_tap
  import jtag_tap_pkg::*;
#(
  parameter int                  IR_WIDTH    = 5,
  parameter logic [31:0]         IDCODE_VAL  = 32'h00000001,
  parameter logic [IR_WIDTH-1:0] USER_IR     = IR_WIDTH'(5'h11),
  parameter int                  SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jtag_TCK,
  input  logic       jtag_TMS,
  input  logic       jtag_TDI,
  input  logic       jtag_TRSTn,
  output logic       jtag_TDO_data,
  output logic       jtag_TDO_driven,
  output logic       user_capture,
  output logic       user_shift,
  output logic       user_update,
  output logic       user_tdi,
  input  logic       user_tdo,
  output logic [3:0] tap_state
);

`ifdef JTAG_TAP_USER_DR_EN
  localparam bit USER_DR_EN = 1'b1;
`else
  localparam bit USER_DR_EN = 1'b0;
`endif
  localparam logic [31:0] IDCODE_EFF = IDCODE_VAL | 32'd1;

  logic tck_s, tms_s, tdi_s, trst_n_s, tck_q;
  logic tck_rise, tck_fall;

  jtag_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_tck  (.clock(clock), .reset(reset), .d(jtag_TCK),   .q(tck_s));
  jtag_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_tms  (.clock(clock), .reset(reset), .d(jtag_TMS),   .q(tms_s));
  jtag_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_tdi  (.clock(clock), .reset(reset), .d(jtag_TDI),   .q(tdi_s));
  jtag_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_trst (.clock(clock), .reset(reset), .d(jtag_TRSTn), .q(trst_n_s));

  assign tck_rise = tck_s & ~tck_q;
  assign tck_fall = ~tck_s & tck_q;

  tap_state_e          state, state_nxt;
  logic [IR_WIDTH-1:0] ir, ir_nxt;
  logic [31:0]         sr, sr_nxt;
  dr_sel_e             dr_sel;
  logic [5:0]          dr_len;

  always_comb begin
    dr_sel = DR_BYPASS;
    if (ir == IR_WIDTH'(IR_IDCODE))                dr_sel = DR_IDCODE;
    else if (ir == IR_WIDTH'(IR_BYPASS))           dr_sel = DR_BYPASS;
    else if (USER_DR_EN && (ir == USER_IR))        dr_sel = DR_USER;
    dr_len = (dr_sel == DR_IDCODE) ? 6'd32 : 6'd1;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    ir_nxt    = ir;
    sr_nxt    = sr;
    if (!trst_n_s) begin
      state_nxt = TEST_LOGIC_RESET;
      ir_nxt    = IR_WIDTH'(IR_IDCODE);
    end else begin
      if (state == TEST_LOGIC_RESET) ir_nxt = IR_WIDTH'(IR_IDCODE);
      if (tck_rise) begin
        state_nxt = tap_next(state, tms_s);
        case (state)
          CAPTURE_IR: sr_nxt = 32'd1;
          SHIFT_IR:   sr_nxt = shift_lsb_first(sr, tdi_s, 6'(IR_WIDTH));
          UPDATE_IR:  ir_nxt = sr[IR_WIDTH-1:0];
          CAPTURE_DR: begin
            if (dr_sel == DR_IDCODE)      sr_nxt = IDCODE_EFF;
            else if (dr_sel == DR_BYPASS) sr_nxt = '0;
          end
          SHIFT_DR:   if (dr_sel != DR_USER) sr_nxt = shift_lsb_first(sr, tdi_s, dr_len);
          default:    ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state           <= TEST_LOGIC_RESET;
      ir              <= IR_WIDTH'(IR_IDCODE);
      sr              <= '0;
      tck_q           <= 1'b0;
      jtag_TDO_data   <= 1'b0;
      jtag_TDO_driven <= 1'b0;
    end else begin
      state <= state_nxt;
      ir    <= ir_nxt;
      sr    <= sr_nxt;
      tck_q <= tck_s;
      // TDO only moves on falling TCK so the driver samples it stable on the next rise.
      if (tck_fall) begin
        jtag_TDO_driven <= (state == SHIFT_IR) || (state == SHIFT_DR);
        jtag_TDO_data   <= ((state == SHIFT_DR) && (dr_sel == DR_USER)) ? user_tdo : sr[0];
      end
    end
  end

`ifdef JTAG_TAP_USER_DR_EN
  logic user_hit;
  assign user_hit = trst_n_s && tck_rise && (dr_sel == DR_USER);

  always_ff @(posedge clock) begin
    if (!reset) begin
      user_capture <= 1'b0;
      user_shift   <= 1'b0;
      user_update  <= 1'b0;
      user_tdi     <= 1'b0;
    end else begin
      user_capture <= user_hit && (state == CAPTURE_DR);
      user_shift   <= user_hit && (state == SHIFT_DR);
      user_update  <= user_hit && (state == UPDATE_DR);
      if (user_hit && (state == SHIFT_DR)) user_tdi <= tdi_s;
    end
  end
`else
  assign user_capture = 1'b0;
  assign user_shift   = 1'b0;
  assign user_update  = 1'b0;
  assign user_tdi     = 1'b0;
`endif

  assign tap_state = state;

endmodule

// File: tb/tb_jtag_sampled_tap.sv
// Self-checking bench for jtag_sampled_tap: TCK-level reference model plus literal spot checks.
module tb_jtag_sampled_tap;
  import jtag_tap_pkg::*;

  localparam logic [31:0] IDCODE = 32'h00000001;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       jtag_TCK = 1'b0, jtag_TMS = 1'b0, jtag_TDI = 1'b0, jtag_TRSTn = 1'b1;
  logic       jtag_TDO_data, jtag_TDO_driven;
  logic       user_capture, user_shift, user_update, user_tdi;
  logic       user_tdo = 1'b0;
  logic [3:0] tap_state;

  always #5 clock = ~clock;

  jtag_sampled_tap #(
    .IR_WIDTH(5), .IDCODE_VAL(IDCODE), .USER_IR(5'h11), .SYNC_STAGES(2)
  ) dut (
    .clock(clock), .reset(reset),
    .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TRSTn(jtag_TRSTn),
    .jtag_TDO_data(jtag_TDO_data), .jtag_TDO_driven(jtag_TDO_driven),
    .user_capture(user_capture), .user_shift(user_shift), .user_update(user_update),
    .user_tdi(user_tdi), .user_tdo(user_tdo), .tap_state(tap_state)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (one step per TCK edge) ----------------
  tap_state_e nxt [16][2];
  tap_state_e m_state = TEST_LOGIC_RESET;
  int         m_ir = 1;
  bit         irq[$], drq[$], rec[$];
  bit         m_driven = 0, m_tdo = 0, m_tck = 0;
  int         exp_cap = 0, exp_shift = 0, exp_upd = 0;
  bit         exp_utdi[$], got_utdi[$];
  int         got_cap = 0, got_shift = 0, got_upd = 0;
  bit         cmp_en = 0;

  task automatic link(input tap_state_e s, input tap_state_e n0, input tap_state_e n1);
    nxt[int'(s)][0] = n0;
    nxt[int'(s)][1] = n1;
  endtask

  function automatic bit m_user();
`ifdef JTAG_TAP_USER_DR_EN
    return m_ir == 17;
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_rise(input bit tms, input bit tdi);
    case (m_state)
      CAPTURE_IR: begin
        irq.delete();
        irq.push_back(1'b1);
        for (int i = 1; i < 5; i++) irq.push_back(1'b0);
      end
      SHIFT_IR: begin irq.delete(0); irq.push_back(tdi); end
      UPDATE_IR: begin
        m_ir = 0;
        foreach (irq[i]) m_ir |= int'(irq[i]) << i;
      end
      CAPTURE_DR: begin
        drq.delete();
        if (m_user()) exp_cap++;
        else if (m_ir == 1) for (int i = 0; i < 32; i++) drq.push_back(IDCODE[i]);
        else drq.push_back(1'b0);
      end
      SHIFT_DR: begin
        if (m_user()) begin exp_shift++; exp_utdi.push_back(tdi); end
        else begin drq.delete(0); drq.push_back(tdi); end
      end
      UPDATE_DR: if (m_user()) exp_upd++;
      default: ;
    endcase
    m_state = nxt[int'(m_state)][int'(tms)];
    if (m_state == TEST_LOGIC_RESET) m_ir = 1;
  endtask

  task automatic m_fall();
    m_driven = (m_state == SHIFT_IR) || (m_state == SHIFT_DR);
    if (m_state == SHIFT_IR)      m_tdo = irq[0];
    else if (m_state == SHIFT_DR) m_tdo = m_user() ? user_tdo : drq[0];
  endtask

  // ---------------- compare process and pulse monitor ----------------
  always @(negedge clock) begin
    if (cmp_en) begin
      check("tap_state", 32'(tap_state), 32'(m_state));
      check("tdo_driven", 32'(jtag_TDO_driven), 32'(m_driven));
      if (m_driven) check("tdo_data", 32'(jtag_TDO_data), 32'(m_tdo));
    end
  end

  always @(negedge clock) begin
    if (user_capture === 1'b1) got_cap++;
    if (user_update === 1'b1)  got_upd++;
    if (user_shift === 1'b1) begin got_shift++; got_utdi.push_back(user_tdi); end
  end

  // ---------------- stimulus helpers ----------------
  task automatic settle();
    repeat (4) @(posedge clock);
    cmp_en = 1'b1;
    repeat (2) @(posedge clock);
    cmp_en = 1'b0;
  endtask

  task automatic tck_cycle(input bit tms, input bit tdi);
    #1;
    jtag_TMS = tms; jtag_TDI = tdi; jtag_TCK = 1'b0;
    if (m_tck) m_fall();
    m_tck = 1'b0;
    settle();
    if (m_driven) rec.push_back(jtag_TDO_data);
    #1;
    jtag_TCK = 1'b1;
    m_rise(tms, tdi);
    m_tck = 1'b1;
    settle();
  endtask

  task automatic load_ir(input logic [4:0] v);
    tck_cycle(1, 0); tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    for (int i = 0; i < 5; i++) tck_cycle(i == 4, v[i]);
    tck_cycle(1, 0); tck_cycle(0, 0);
  endtask

  task automatic shift_dr(input int n, input logic [31:0] data);
    tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    rec.delete();
    for (int i = 0; i < n; i++) tck_cycle(i == n - 1, data[i]);
    tck_cycle(1, 0); tck_cycle(0, 0);
  endtask

  function automatic logic [31:0] pack(input bit q[$]);
    logic [31:0] r = '0;
    foreach (q[i]) if (i < 32) r[i] = q[i];
    return r;
  endfunction

  task automatic do_reset();
    #1;
    reset = 1'b0; jtag_TCK = 1'b0; jtag_TMS = 1'b0; jtag_TDI = 1'b0; jtag_TRSTn = 1'b1;
    m_state = TEST_LOGIC_RESET; m_ir = 1; m_driven = 0; m_tdo = 0; m_tck = 0;
    irq.delete(); drq.delete();
    @(posedge clock);
    @(negedge clock);
    check("rst_state", 32'(tap_state), 32'hF);
    check("rst_driven", 32'(jtag_TDO_driven), 32'h0);
    check("rst_tdo", 32'(jtag_TDO_data), 32'h0);
    check("rst_user", {29'd0, user_capture, user_shift, user_update}, 32'h0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    settle();
  endtask

  initial begin
    link(TEST_LOGIC_RESET, RUN_TEST_IDLE, TEST_LOGIC_RESET);
    link(RUN_TEST_IDLE,    RUN_TEST_IDLE, SELECT_DR);
    link(SELECT_DR,        CAPTURE_DR,    SELECT_IR);
    link(CAPTURE_DR,       SHIFT_DR,      EXIT1_DR);
    link(SHIFT_DR,         SHIFT_DR,      EXIT1_DR);
    link(EXIT1_DR,         PAUSE_DR,      UPDATE_DR);
    link(PAUSE_DR,         PAUSE_DR,      EXIT2_DR);
    link(EXIT2_DR,         SHIFT_DR,      UPDATE_DR);
    link(UPDATE_DR,        RUN_TEST_IDLE, SELECT_DR);
    link(SELECT_IR,        CAPTURE_IR,    TEST_LOGIC_RESET);
    link(CAPTURE_IR,       SHIFT_IR,      EXIT1_IR);
    link(SHIFT_IR,         SHIFT_IR,      EXIT1_IR);
    link(EXIT1_IR,         PAUSE_IR,      UPDATE_IR);
    link(PAUSE_IR,         PAUSE_IR,      EXIT2_IR);
    link(EXIT2_IR,         SHIFT_IR,      UPDATE_IR);
    link(UPDATE_IR,        RUN_TEST_IDLE, SELECT_DR);

    // 1: reset, then release with TCK idle
    do_reset();
    check("post_rst_state", 32'(tap_state), 32'hF);

    // 2: IDCODE read straight out of reset (TMS 0,1,0,0 then 32 shifts)
    tck_cycle(0, 0); tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    rec.delete();
    for (int i = 0; i < 32; i++) tck_cycle(i == 31, 0);
    check("idcode_stream", pack(rec), 32'h00000001);
    check("idcode_len", 32'(rec.size()), 32'd32);
    tck_cycle(1, 0); tck_cycle(0, 0);

    // 3: IR=1F -> BYPASS, 8 bits 1,0,1,1,0,0,1,1 in; TDO = 0 then TDI one TCK late
    load_ir(5'h1F);
    shift_dr(8, 32'hCD);
    check("bypass_stream", pack(rec), 32'h9A);

    // 4a: five TMS=1 from Shift-DR reach TLR; IR back to IDCODE
    tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    for (int i = 0; i < 5; i++) tck_cycle(1, 0);
    check("tms5_tlr", 32'(tap_state), 32'hF);
    tck_cycle(0, 0);
    shift_dr(32, 32'h0);
    check("tlr_idcode", pack(rec), 32'h00000001);

    // 4b: TRSTn mid-Shift-IR -> TLR, partial IR never updated
    tck_cycle(1, 0); tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    tck_cycle(0, 1); tck_cycle(0, 1);
    #1;
    jtag_TCK = 1'b0; jtag_TRSTn = 1'b0;
    if (m_tck) m_fall();
    m_tck = 1'b0; m_state = TEST_LOGIC_RESET; m_ir = 1;
    settle();
    check("trst_tlr", 32'(tap_state), 32'hF);
    #1 jtag_TRSTn = 1'b1;
    settle();
    tck_cycle(0, 0);
    shift_dr(32, 32'h0);
    check("trst_idcode", pack(rec), 32'h00000001);

    // 5: USER instruction, 4-bit shift of 1,0,1,1 with user_tdo held high
    user_tdo = 1'b1;
    load_ir(5'h11);
    shift_dr(4, 32'hD);
    check("user_cap_cnt", 32'(got_cap), 32'(exp_cap));
    check("user_shift_cnt", 32'(got_shift), 32'(exp_shift));
    check("user_upd_cnt", 32'(got_upd), 32'(exp_upd));
    check("user_tdi_stream", pack(got_utdi), pack(exp_utdi));
`ifdef JTAG_TAP_USER_DR_EN
    check("user_pulses_lit", {got_cap[7:0], got_shift[7:0], got_upd[7:0]}, 32'h010401);
    check("user_tdi_lit", pack(got_utdi), 32'hD);
    check("user_tdo_lit", pack(rec), 32'hF);
`else
    check("user_pulses_lit", {got_cap[7:0], got_shift[7:0], got_upd[7:0]}, 32'h0);
    check("user_bypass_lit", pack(rec), 32'hA);
`endif

    // 6: reset in the middle of Shift-DR: abandon, no update pulse
    tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    tck_cycle(0, 1); tck_cycle(0, 0);
    tck_cycle(0, 1);
    do_reset();
    check("midrst_upd_cnt", 32'(got_upd), 32'(exp_upd));
`ifdef JTAG_TAP_USER_DR_EN
    check("midrst_upd_lit", 32'(got_upd), 32'd1);
`else
    check("midrst_upd_lit", 32'(got_upd), 32'd0);
`endif
    check("midrst_final_state", 32'(tap_state), 32'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
